// File: rtl/lc2k_exec_unit.sv
// rtl/lc2k_exec_unit.sv - LC2K execute stage: operand-B mux, ALU, branch compare
// and halt-gated result/branch/cycle registers.
module lc2k_exec_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] aluValA,
  input  logic [31:0] regBvalue,
  input  logic [31:0] offsetExtended,
  input  logic        CONTROL_ALUvalB,
  input  logic [1:0]  CONTROL_OPERATION,
  input  logic        CONTROL_HALT,
  output logic [31:0] aluValB,
  output logic [31:0] aluResult,
  output logic        CONTROL_BEQ,
  output logic [31:0] aluResult_q,
  output logic        beq_q,
  output logic [31:0] cycle_count
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_NOR = 2'b01;
  localparam logic [1:0] OP_MEM = 2'b10;
  localparam logic [1:0] OP_BEQ = 2'b11;

  logic [31:0] result_d, result_q;
  logic        beq_d, beq_reg_q;
  logic [31:0] cycle_d, cycle_q;

  assign aluValB = CONTROL_ALUvalB ? offsetExtended : regBvalue;

  always_comb begin
    result_d = 32'd0;
    case (CONTROL_OPERATION)
      OP_ADD:  result_d = aluValA + aluValB;
      OP_NOR:  result_d = ~(aluValA | aluValB);
      OP_MEM:  result_d = aluValA + aluValB;
      OP_BEQ:  result_d = aluValA - aluValB;
      default: result_d = 32'd0;
    endcase
  end

  assign aluResult = result_d;
  // Branch flag is only meaningful for the subtract/compare operation.
  assign beq_d       = (CONTROL_OPERATION == OP_BEQ) && (aluValA == aluValB);
  assign CONTROL_BEQ = beq_d;
  assign cycle_d     = cycle_q + 32'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q  <= 32'd0;
      beq_reg_q <= 1'b0;
      cycle_q   <= 32'd0;
    end else if (!CONTROL_HALT) begin
      result_q  <= result_d;
      beq_reg_q <= beq_d;
      cycle_q   <= cycle_d;
    end
  end

  assign aluResult_q = result_q;
  assign beq_q       = beq_reg_q;
  assign cycle_count = cycle_q;

endmodule

// File: tb/tb_lc2k_exec_unit.sv
// tb/tb_lc2k_exec_unit.sv - directed self-checking bench for lc2k_exec_unit.
module tb_lc2k_exec_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] aluValA;
  logic [31:0] regBvalue;
  logic [31:0] offsetExtended;
  logic        CONTROL_ALUvalB;
  logic [1:0]  CONTROL_OPERATION;
  logic        CONTROL_HALT;
  logic [31:0] aluValB;
  logic [31:0] aluResult;
  logic        CONTROL_BEQ;
  logic [31:0] aluResult_q;
  logic        beq_q;
  logic [31:0] cycle_count;

  int tests_run = 0;
  int tests_failed = 0;

  lc2k_exec_unit dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .aluValA           (aluValA),
    .regBvalue         (regBvalue),
    .offsetExtended    (offsetExtended),
    .CONTROL_ALUvalB   (CONTROL_ALUvalB),
    .CONTROL_OPERATION (CONTROL_OPERATION),
    .CONTROL_HALT      (CONTROL_HALT),
    .aluValB           (aluValB),
    .aluResult         (aluResult),
    .CONTROL_BEQ       (CONTROL_BEQ),
    .aluResult_q       (aluResult_q),
    .beq_q             (beq_q),
    .cycle_count       (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] rb, input logic [31:0] off,
                       input logic sel, input logic [1:0] op);
    aluValA           = a;
    regBvalue         = rb;
    offsetExtended    = off;
    CONTROL_ALUvalB   = sel;
    CONTROL_OPERATION = op;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    CONTROL_HALT = 1'b0;
    drive(32'd0, 32'd0, 32'd0, 1'b0, 2'b00);
    #2;
    check("rst_result_q", aluResult_q, 32'd0);
    check("rst_beq_q", {31'd0, beq_q}, 32'd0);
    check("rst_cycle", cycle_count, 32'd0);

    // combinational paths keep working while reset is held
    drive(32'd5, 32'd3, 32'hFFFFFFFE, 1'b1, 2'b00);
    check("mux_offset", aluValB, 32'hFFFFFFFE);
    check("add_offset", aluResult, 32'd3);
    drive(32'd5, 32'd3, 32'hFFFFFFFE, 1'b0, 2'b00);
    check("mux_regb", aluValB, 32'd3);
    check("add_regb", aluResult, 32'd8);

    @(negedge clk);
    rst_n = 1'b1;
    drive(32'h0000FFFF, 32'h00FF00FF, 32'd0, 1'b0, 2'b01);
    check("nor_result", aluResult, 32'hFF000000);
    check("nor_beq", {31'd0, CONTROL_BEQ}, 32'd0);
    edge_step();
    check("first_capture", aluResult_q, 32'hFF000000);
    check("first_cycle", cycle_count, 32'd1);

    drive(32'h12345678, 32'h12345678, 32'd0, 1'b0, 2'b11);
    check("beq_eq_result", aluResult, 32'd0);
    check("beq_eq_flag", {31'd0, CONTROL_BEQ}, 32'd1);
    edge_step();
    check("beq_q_set", {31'd0, beq_q}, 32'd1);
    check("cycle2", cycle_count, 32'd2);
    drive(32'h12345678, 32'h12345678, 32'd0, 1'b0, 2'b00);
    check("add_eq_noflag", {31'd0, CONTROL_BEQ}, 32'd0);
    check("add_eq_result", aluResult, 32'h2468ACF0);

    drive(32'd1, 32'd2, 32'd0, 1'b0, 2'b11);
    check("sub_neg", aluResult, 32'hFFFFFFFF);
    check("sub_ne_flag", {31'd0, CONTROL_BEQ}, 32'd0);
    edge_step();
    check("cycle3", cycle_count, 32'd3);
    check("sub_q", aluResult_q, 32'hFFFFFFFF);
    check("beq_q_clr", {31'd0, beq_q}, 32'd0);

    drive(32'h10, 32'd0, 32'hFFFFFFFC, 1'b1, 2'b10);
    check("mem_addr", aluResult, 32'h0000000C);

    // halt: registers freeze while combinational outputs follow the inputs
    CONTROL_HALT = 1'b1;
    drive(32'd7, 32'd1, 32'd0, 1'b0, 2'b00);
    check("halt_comb", aluResult, 32'd8);
    edge_step();
    drive(32'd9, 32'd9, 32'd0, 1'b0, 2'b11);
    edge_step();
    check("halt_cycle", cycle_count, 32'd3);
    check("halt_result_q", aluResult_q, 32'hFFFFFFFF);
    check("halt_beq_q", {31'd0, beq_q}, 32'd0);
    CONTROL_HALT = 1'b0;
    drive(32'd7, 32'd1, 32'd0, 1'b0, 2'b00);
    edge_step();
    check("unhalt_cycle", cycle_count, 32'd4);
    check("unhalt_result_q", aluResult_q, 32'd8);

    // wrap-around of the adder and of the cycle counter
    @(negedge clk);
    drive(32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 2'b00);
    check("add_wrap", aluResult, 32'd0);
    force dut.cycle_q = 32'hFFFFFFFF;
    #1;
    release dut.cycle_q;
    #1;
    check("cycle_preload", cycle_count, 32'hFFFFFFFF);
    edge_step();
    check("cycle_wrap", cycle_count, 32'd0);
    check("wrap_result_q", aluResult_q, 32'd0);

    drive(32'd5, 32'd5, 32'd0, 1'b0, 2'b11);
    edge_step();
    check("pre_rst_beq_q", {31'd0, beq_q}, 32'd1);
    drive(32'd3, 32'd4, 32'd0, 1'b0, 2'b00);
    edge_step();
    check("pre_rst_result_q", aluResult_q, 32'd7);
    check("pre_rst_cycle", cycle_count, 32'd2);

    // async reset between edges, with halt asserted
    @(negedge clk);
    CONTROL_HALT = 1'b1;
    drive(32'd5, 32'd5, 32'd0, 1'b0, 2'b11);
    rst_n = 1'b0;
    #1;
    check("async_result_q", aluResult_q, 32'd0);
    check("async_beq_q", {31'd0, beq_q}, 32'd0);
    check("async_cycle", cycle_count, 32'd0);
    check("async_comb_beq", {31'd0, CONTROL_BEQ}, 32'd1);
    rst_n = 1'b1;
    CONTROL_HALT = 1'b0;
    drive(32'd10, 32'd3, 32'd0, 1'b0, 2'b11);
    check("post_rst_hold", cycle_count, 32'd0);
    edge_step();
    check("post_rst_result_q", aluResult_q, 32'd7);
    check("post_rst_cycle", cycle_count, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lc2k_exec_unit.md
LC2K_EXEC_UNIT -- requirements
Module: lc2k_exec_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 Port `clk`: input, 1 bit; single clock; all state updates on its rising edge.
REQ-003 Port `rst_n`: input, 1 bit; asynchronous active-low reset.
REQ-004 Port `aluValA`: input, 32 bits; ALU operand A (regA value).
REQ-005 Port `regBvalue`: input, 32 bits; regB value.
REQ-006 Port `offsetExtended`: input, 32 bits; sign-extended 16-bit offset.
REQ-007 Port `CONTROL_ALUvalB`: input, 1 bit; operand-B select, 1 = offsetExtended, 0 = regBvalue.
REQ-008 Port `CONTROL_OPERATION`: input, 2 bits; ALU operation select.
REQ-009 Port `CONTROL_HALT`: input, 1 bit; freezes the registered state.
REQ-010 Port `aluValB`: output, 32 bits; selected operand B (combinational).
REQ-011 Port `aluResult`: output, 32 bits; ALU result (combinational).
REQ-012 Port `CONTROL_BEQ`: output, 1 bit; branch-taken flag (combinational).
REQ-013 Port `aluResult_q`: output, 32 bits; aluResult registered.
REQ-014 Port `beq_q`: output, 1 bit; CONTROL_BEQ registered.
REQ-015 Port `cycle_count`: output, 32 bits; count of clock cycles not halted.

Function
REQ-016 aluValB SHALL equal offsetExtended when CONTROL_ALUvalB=1, otherwise regBvalue, with zero latency.
REQ-017 aluResult SHALL follow CONTROL_OPERATION combinationally: 00 = A+B; 01 = ~(A|B); 10 = A+B (lw/sw address); 11 = A-B. A is aluValA and B is aluValB.
REQ-018 All arithmetic SHALL be 32-bit two's complement modulo 2^32, with no carry or overflow output; 0xFFFFFFFF+1 = 0 and 0-1 = 0xFFFFFFFF.
REQ-019 CONTROL_BEQ SHALL be 1 only when CONTROL_OPERATION=11 and aluValA==aluValB over all 32 bits, and 0 for every other operation.
REQ-020 On each rising clk edge with rst_n=1 and CONTROL_HALT=0, aluResult_q SHALL load aluResult, beq_q SHALL load CONTROL_BEQ, and cycle_count SHALL increment by 1, so registered outputs have 1-cycle latency.
REQ-021 When CONTROL_HALT=1 at a rising edge, all registers SHALL hold their values; the combinational outputs still track the inputs.
REQ-022 cycle_count SHALL wrap from 0xFFFFFFFF to 0x00000000 without flagging.
REQ-023 Combinational paths SHALL contain no latches, and unknown operand bits SHALL propagate normally, with no special-casing.

Reset
REQ-024 When rst_n=0, aluResult_q, beq_q and cycle_count SHALL go to 0 immediately, independent of clk.
REQ-025 Reset SHALL dominate CONTROL_HALT.
REQ-026 Reset asserted mid-operation SHALL discard the pending capture.
REQ-027 After rst_n deasserts, the first rising edge SHALL perform a normal capture, and cycle_count SHALL become 1.
REQ-028 Combinational outputs SHALL be unaffected by reset.

Verification
REQ-029 Mux and add: A=5, regB=3, offset=0xFFFFFFFE, ALUvalB=1, op=00 -> aluValB=0xFFFFFFFE and aluResult=3; with ALUvalB=0 -> aluResult=8.
REQ-030 Nor: A=0x0000FFFF, B=0x00FF00FF, op=01 -> aluResult=0xFF000000, CONTROL_BEQ=0.
REQ-031 Branch compare: A=B=0x12345678, op=11 -> aluResult=0, CONTROL_BEQ=1; same operands with op=00 -> CONTROL_BEQ=0; A=1, B=2, op=11 -> aluResult=0xFFFFFFFF, CONTROL_BEQ=0.
REQ-032 Wrap-around: A=0xFFFFFFFF, B=1, op=00 -> aluResult=0; force cycle_count to 0xFFFFFFFF via a long run or a bench backdoor, then one clock -> 0.
REQ-033 Halt: run 3 cycles -> cycle_count=3; assert HALT for 2 edges with changing inputs -> cycle_count=3 and aluResult_q unchanged; deassert HALT -> next edge cycle_count=4.
REQ-034 Async reset: drive rst_n low between clock edges with HALT=1 -> aluResult_q, beq_q and cycle_count read 0 before the next edge; release -> first edge captures aluResult and cycle_count=1.
